// File: rtl/vga_frame_painter.sv
// rtl/vga_frame_painter.sv - copies one ROM image per V_SYNC frame into a framebuffer, with a 4x4 cursor overlay
module vga_frame_painter #(
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int COLOR_W = 3,
  parameter int NUM_SCREENS = 4,
  parameter int ROM_LAT = 1,
  parameter logic [COLOR_W-1:0] CURSOR_COLOR = '1,
  localparam int SEL_W = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1,
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1,
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1,
  localparam int AW = (H_RES * V_RES > 1) ? $clog2(H_RES * V_RES) : 1
) (
  input  logic               clk,
  input  logic               iReset,
  input  logic               V_SYNC,
  input  logic [SEL_W-1:0]   iScreenSel,
  input  logic               iSelValid,
  input  logic               iCursorEn,
  input  logic [XW-1:0]      iCursorX,
  input  logic [YW-1:0]      iCursorY,
  output logic [SEL_W-1:0]   oRomScreen,
  output logic [AW-1:0]      oRomAddr,
  input  logic [COLOR_W-1:0] iRomData,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic [COLOR_W-1:0] color,
  output logic               writeEn,
  output logic               oBusy,
  output logic               oFrameDone,
  output logic               oFrameMissed
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;
  state_t state, state_nxt;

  logic       vs_q, vs_prev;
  logic [1:0] vs_live;
  logic       frame_start, start, last_write, iss_last;
  logic [2:0] fetch_cnt;

  logic             iss_valid;
  logic [XW-1:0]    ix;
  logic [YW-1:0]    iy;
  logic [SEL_W-1:0] pending;
  logic             cur_en;
  logic [XW-1:0]    cur_x;
  logic [YW-1:0]    cur_y;

  logic [XW-1:0]      tag_x [ROM_LAT];
  logic [YW-1:0]      tag_y [ROM_LAT];
  logic [ROM_LAT-1:0] tag_v;

  // vs_live blocks edges until vs_prev holds a real post-reset sample,
  // so a V_SYNC already low at reset release does not start a frame
  always_ff @(posedge clk) begin
    if (iReset) begin
      vs_q    <= 1'b1;
      vs_prev <= 1'b1;
      vs_live <= 2'b00;
    end else begin
      vs_q    <= V_SYNC;
      vs_prev <= vs_q;
      vs_live <= {vs_live[0], 1'b1};
    end
  end

  assign frame_start = vs_live[1] & vs_prev & ~vs_q;
  assign last_write  = writeEn && (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));
  assign iss_last    = (ix == XW'(H_RES - 1)) && (iy == YW'(V_RES - 1));

  always_ff @(posedge clk) begin
    if (iReset) begin
      state     <= IDLE;
      fetch_cnt <= 3'd0;
    end else begin
      state     <= state_nxt;
      fetch_cnt <= (state == FETCH) ? fetch_cnt + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    oBusy        = 1'b0;
    oFrameMissed = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) begin
          state_nxt = FETCH;
          start     = 1'b1;
        end
      end
      FETCH: begin
        oBusy        = 1'b1;
        oFrameMissed = frame_start;
        if (fetch_cnt == 3'(ROM_LAT - 1)) state_nxt = DRAW;
      end
      DRAW: begin
        oBusy        = 1'b1;
        oFrameMissed = frame_start;
        if (last_write) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      pending    <= '0;
      oRomScreen <= '0;
      cur_en     <= 1'b0;
      cur_x      <= '0;
      cur_y      <= '0;
      iss_valid  <= 1'b0;
      ix         <= '0;
      iy         <= '0;
      oRomAddr   <= '0;
    end else begin
      if (iSelValid && (int'(iScreenSel) < NUM_SCREENS)) pending <= iScreenSel;
      if (start) begin
        oRomScreen <= pending;
        cur_en     <= iCursorEn;
        cur_x      <= iCursorX;
        cur_y      <= iCursorY;
        iss_valid  <= 1'b1;
        ix         <= '0;
        iy         <= '0;
        oRomAddr   <= '0;
      end else if (iss_valid) begin
        // counters hold on the last pixel so the address never leaves the image
        if (iss_last) begin
          iss_valid <= 1'b0;
        end else begin
          oRomAddr <= oRomAddr + AW'(1);
          if (ix == XW'(H_RES - 1)) begin
            ix <= '0;
            iy <= iy + YW'(1);
          end else begin
            ix <= ix + XW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      tag_v <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_x[i] <= '0;
        tag_y[i] <= '0;
      end
    end else begin
      tag_v[0] <= iss_valid;
      tag_x[0] <= ix;
      tag_y[0] <= iy;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_x[i] <= tag_x[i-1];
        tag_y[i] <= tag_y[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (iReset) oFrameDone <= 1'b0;
    else        oFrameDone <= last_write;
  end

  assign writeEn = tag_v[ROM_LAT-1];
  assign x       = tag_x[ROM_LAT-1];
  assign y       = tag_y[ROM_LAT-1];

  // widened compares clip the cursor at the right/bottom edge instead of wrapping
  logic hit;
  assign hit = cur_en
            && ({2'b00, x} >= {2'b00, cur_x}) && ({2'b00, x} <= {2'b00, cur_x} + (XW+2)'(3))
            && ({2'b00, y} >= {2'b00, cur_y}) && ({2'b00, y} <= {2'b00, cur_y} + (YW+2)'(3));

  assign color = hit ? CURSOR_COLOR : iRomData;

endmodule

// File: tb/tb_vga_frame_painter.sv
// tb/tb_vga_frame_painter.sv - scoreboard bench: full default frame plus small-geometry corner cases
module tb_vga_frame_painter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct { int x; int y; int c; } pix_t;

  // ---------------- small instance: 8x4, ROM_LAT=3, 3 screens
  localparam int SH = 8, SV = 4, SL = 3, SN = 3, SP = SH * SV;
  logic       s_rst, s_vs, s_selv, s_cen;
  logic [1:0] s_sel, s_cy, s_scr, s_y;
  logic [2:0] s_cx, s_x;
  logic [4:0] s_addr;
  logic [6:0] s_rom, s_color;
  logic       s_we, s_busy, s_done, s_missed;

  vga_frame_painter #(.H_RES(SH), .V_RES(SV), .COLOR_W(7), .NUM_SCREENS(SN), .ROM_LAT(SL)) dut_s (
    .clk(clk), .iReset(s_rst), .V_SYNC(s_vs), .iScreenSel(s_sel), .iSelValid(s_selv),
    .iCursorEn(s_cen), .iCursorX(s_cx), .iCursorY(s_cy), .oRomScreen(s_scr), .oRomAddr(s_addr),
    .iRomData(s_rom), .x(s_x), .y(s_y), .color(s_color), .writeEn(s_we), .oBusy(s_busy),
    .oFrameDone(s_done), .oFrameMissed(s_missed)
  );

  logic [6:0] s_rp [SL];
  always @(posedge clk) begin
    s_rp[0] <= {s_scr, s_addr};
    for (int i = 1; i < SL; i++) s_rp[i] <= s_rp[i-1];
  end
  assign s_rom = s_rp[SL-1];

  pix_t s_q[$];
  int s_writes = 0, s_err = 0, s_cur = 0, s_first = -1, s_done_cyc = -1;
  int s_done_cnt = 0, s_miss_cnt = 0, s_drive = 0;
  always @(negedge clk) begin
    pix_t e;
    if (s_we === 1'b1) begin
      if (s_writes == 0) s_first = cyc;
      s_writes++;
      if (s_color === 7'h7f) s_cur++;
      if (s_q.size() == 0) s_err++;
      else begin
        e = s_q.pop_front();
        if (e.x !== int'(s_x) || e.y !== int'(s_y) || e.c !== int'(s_color)) s_err++;
      end
    end
    if (s_missed === 1'b1) s_miss_cnt++;
    if (s_done === 1'b1) begin
      s_done_cnt++;
      if (s_done_cyc < 0) s_done_cyc = cyc;
    end
  end

  task automatic s_push_frame(input int scr, input int en, input int cx, input int cy);
    for (int yy = 0; yy < SV; yy++)
      for (int xx = 0; xx < SH; xx++) begin
        pix_t p;
        p.x = xx;
        p.y = yy;
        p.c = (en != 0 && xx >= cx && xx <= cx + 3 && yy >= cy && yy <= cy + 3) ? 127
              : scr * 32 + yy * SH + xx;
        s_q.push_back(p);
      end
  endtask

  task automatic s_start(input int scr, input int en, input int cx, input int cy);
    @(posedge clk); #1;
    s_writes = 0; s_err = 0; s_cur = 0; s_first = -1; s_done_cyc = -1;
    s_done_cnt = 0; s_miss_cnt = 0;
    s_cen = en[0]; s_cx = 3'(cx); s_cy = 2'(cy);
    s_push_frame(scr, en, cx, cy);
    s_vs = 1'b0;
    s_drive = cyc;
    repeat (3) @(posedge clk);
    #1 s_vs = 1'b1;
  endtask

  task automatic s_wait_done(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (s_done_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic s_wait_writes(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (s_writes >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic s_frame_checks(input string tag, input int exp_cur, input int exp_miss);
    check({tag, " writes"}, s_writes, SP);
    check({tag, " pixel errors"}, s_err, 0);
    check({tag, " queue left"}, s_q.size(), 0);
    check({tag, " cursor pixels"}, s_cur, exp_cur);
    check({tag, " done offset"}, s_done_cyc - s_first, SP);
    check({tag, " first write latency"}, s_first - s_drive, 2 + SL);
    check({tag, " missed pulses"}, s_miss_cnt, exp_miss);
  endtask

  // ---------------- default instance: 320x240, ROM_LAT=1
  localparam int DH = 320, DV = 240, DP = DH * DV;
  logic        d_rst, d_vs, d_selv, d_cen;
  logic [1:0]  d_sel, d_scr;
  logic [8:0]  d_cx, d_x;
  logic [7:0]  d_cy, d_y;
  logic [16:0] d_addr;
  logic [2:0]  d_rom, d_color;
  logic        d_we, d_busy, d_done, d_missed;

  vga_frame_painter dut_d (
    .clk(clk), .iReset(d_rst), .V_SYNC(d_vs), .iScreenSel(d_sel), .iSelValid(d_selv),
    .iCursorEn(d_cen), .iCursorX(d_cx), .iCursorY(d_cy), .oRomScreen(d_scr), .oRomAddr(d_addr),
    .iRomData(d_rom), .x(d_x), .y(d_y), .color(d_color), .writeEn(d_we), .oBusy(d_busy),
    .oFrameDone(d_done), .oFrameMissed(d_missed)
  );

  always @(posedge clk) d_rom <= 3'((int'(d_addr) + int'(d_scr)) % 7);

  pix_t d_q[$];
  int d_writes = 0, d_err = 0, d_cur = 0, d_first = -1, d_last = -1, d_done_cyc = -1;
  int d_p00 = -1, d_miss_cnt = 0, d_drive = 0;
  always @(negedge clk) begin
    pix_t e;
    if (d_we === 1'b1) begin
      if (d_writes == 0) d_first = cyc;
      d_last = cyc;
      d_writes++;
      if (d_color === 3'h7) d_cur++;
      if (d_x == 9'd0 && d_y == 8'd0) d_p00 = int'(d_color);
      if (d_q.size() == 0) d_err++;
      else begin
        e = d_q.pop_front();
        if (e.x !== int'(d_x) || e.y !== int'(d_y) || e.c !== int'(d_color)) d_err++;
      end
    end
    if (d_missed === 1'b1) d_miss_cnt++;
    if (d_done === 1'b1 && d_done_cyc < 0) d_done_cyc = cyc;
  end

  typedef struct { int en; int cx; int cy; int exp_cur; } vec_t;
  vec_t vt[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int exp_pend, w0, bad;
    vt[0] = '{0, 2, 1, 0};
    vt[1] = '{1, 0, 0, 16};
    vt[2] = '{1, 6, 2, 4};
    vt[3] = '{1, 7, 3, 1};
    vt[4] = '{1, 3, 0, 16};
    vt[5] = '{1, 5, 1, 9};
    exp_pend = 0;

    s_rst = 1; s_vs = 1; s_selv = 0; s_sel = 0; s_cen = 0; s_cx = 0; s_cy = 0;
    d_rst = 1; d_vs = 1; d_selv = 0; d_sel = 0; d_cen = 0; d_cx = 0; d_cy = 0;
    repeat (3) @(posedge clk);
    #1 s_rst = 0; d_rst = 0;
    @(negedge clk);
    check("reset writeEn", s_we, 0);
    check("reset busy", s_busy, 0);
    check("reset done", s_done, 0);
    check("reset missed", s_missed, 0);
    check("reset x", s_x, 0);
    check("reset y", s_y, 0);
    check("reset addr", s_addr, 0);
    check("reset screen", s_scr, 0);
    check("reset default busy", d_busy, 0);
    check("reset default writeEn", d_we, 0);
    repeat (3) @(posedge clk);

    for (int i = 0; i < 6; i++) begin
      s_start(exp_pend, vt[i].en, vt[i].cx, vt[i].cy);
      s_wait_done(1, ok);
      check($sformatf("vec%0d done seen", i), ok, 1);
      check($sformatf("vec%0d busy after done", i), s_busy, 0);
      s_frame_checks($sformatf("vec%0d", i), vt[i].exp_cur, 0);
    end

    // screen select mid-frame, then an out-of-range select
    s_start(exp_pend, 0, 0, 0);
    s_wait_writes(10, ok);
    check("sel wait", ok, 1);
    check("sel busy mid-frame", s_busy, 1);
    @(posedge clk); #1 s_sel = 2'd2; s_selv = 1;
    @(posedge clk); #1 s_selv = 0;
    check("sel screen held", s_scr, 0);
    s_wait_done(1, ok);
    check("sel frame done", ok, 1);
    s_frame_checks("sel frame a", 0, 0);
    exp_pend = 2;
    @(posedge clk); #1 s_sel = 2'd3; s_selv = 1;
    @(posedge clk); #1 s_selv = 0;
    s_start(exp_pend, 0, 0, 0);
    s_wait_writes(5, ok);
    check("sel screen next frame", s_scr, 2);
    s_wait_done(1, ok);
    check("sel frame b done", ok, 1);
    s_frame_checks("sel frame b", 0, 0);

    // second falling edge mid-frame
    s_start(exp_pend, 0, 0, 0);
    s_wait_writes(10, ok);
    @(posedge clk); #1 s_vs = 0;
    repeat (2) @(posedge clk);
    #1 s_vs = 1;
    s_wait_done(1, ok);
    check("missed frame done", ok, 1);
    s_frame_checks("missed", 0, 1);

    // frame start landing in the done cycle
    s_start(exp_pend, 1, 2, 1);
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (s_we === 1'b1 && s_x == 3'd7 && s_y == 2'd3) begin ok = 1; break; end
    end
    check("b2b last write seen", ok, 1);
    s_push_frame(exp_pend, 1, 2, 1);
    s_vs = 0;
    repeat (2) @(posedge clk);
    #1 s_vs = 1;
    s_wait_done(2, ok);
    check("b2b second done", ok, 1);
    check("b2b writes", s_writes, 2 * SP);
    check("b2b pixel errors", s_err, 0);
    check("b2b missed", s_miss_cnt, 0);
    check("b2b cursor pixels", s_cur, 24);

    // reset mid-frame with V_SYNC low across release
    s_start(exp_pend, 0, 0, 0);
    s_wait_writes(20, ok);
    check("rst wait", ok, 1);
    @(posedge clk); #1 s_rst = 1; s_vs = 0;
    @(posedge clk); #1 s_rst = 0;
    @(negedge clk);
    check("rst writeEn", s_we, 0);
    check("rst busy", s_busy, 0);
    check("rst x", s_x, 0);
    check("rst y", s_y, 0);
    check("rst addr", s_addr, 0);
    check("rst screen", s_scr, 0);
    check("rst done", s_done, 0);
    check("rst missed", s_missed, 0);
    exp_pend = 0;
    s_q.delete();
    w0 = s_writes;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (s_busy !== 1'b0 || s_we !== 1'b0) bad++;
    end
    check("no start from low V_SYNC", bad, 0);
    check("no writes after reset", s_writes - w0, 0);
    @(posedge clk); #1 s_vs = 1;
    repeat (3) @(posedge clk);
    s_start(exp_pend, 0, 0, 0);
    s_wait_done(1, ok);
    check("post-reset frame done", ok, 1);
    s_frame_checks("post-reset", 0, 0);

    // full default-size frame with the cursor in the bottom-right corner
    d_cen = 1; d_cx = 9'd318; d_cy = 8'd238;
    for (int yy = 0; yy < DV; yy++)
      for (int xx = 0; xx < DH; xx++) begin
        pix_t p;
        p.x = xx;
        p.y = yy;
        p.c = (xx >= 318 && xx <= 321 && yy >= 238 && yy <= 241) ? 7 : (yy * DH + xx) % 7;
        d_q.push_back(p);
      end
    @(posedge clk); #1 d_vs = 0;
    d_drive = cyc;
    repeat (3) @(posedge clk);
    #1 d_vs = 1;
    for (int t = 0; t < 80000 && d_done_cyc < 0; t++) @(negedge clk);
    check("default done seen", d_done_cyc >= 0, 1);
    check("default first write latency", d_first - d_drive, 3);
    check("default writes", d_writes, DP);
    check("default consecutive", d_last - d_first, DP - 1);
    check("default done offset", d_done_cyc - d_first, DP);
    check("default pixel errors", d_err, 0);
    check("default queue left", d_q.size(), 0);
    check("default cursor pixels", d_cur, 4);
    check("default pixel 0,0", d_p00, 0);
    check("default missed", d_miss_cnt, 0);
    @(negedge clk);
    check("default busy after", d_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
